// File: rtl/req_issuer_pkg.sv
// Shared types and default sizing for the request issuer and its per-client counters.
package req_issuer_pkg;

  localparam int unsigned N_CLIENTS = 4;
  localparam int unsigned BEATS     = 4;
  localparam int unsigned CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    BURST
  } state_t;

endpackage

// File: rtl/req_issuer_req_counter.sv
// Saturating up/down pending-job counter for one client; exposes ready/req and the
// request state the counter will hold after the current edge.
module req_counter #(
  parameter int unsigned CNT_W = req_issuer_pkg::CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  output logic job_ready,
  output logic req,
  output logic req_nxt_c
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             inc;

  assign job_ready = (cnt != '1);
  assign req       = (cnt != '0);
  assign inc       = push & job_ready;
  assign req_nxt_c = (cnt_nxt != '0);

  // Simultaneous push and pop cancel out.
  always_comb begin
    cnt_nxt = cnt;
    if (inc && !pop) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else if (!inc && pop && req) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/req_issuer.sv
// Collects per-client jobs, arbitrates through an external priority selector and
// issues one fixed-length bus burst per grant.
module req_issuer #(
  parameter int unsigned N_CLIENTS = req_issuer_pkg::N_CLIENTS,
  parameter int unsigned BEATS     = req_issuer_pkg::BEATS,
  parameter int unsigned CNT_W     = req_issuer_pkg::CNT_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_CLIENTS-1:0]         job_valid,
  output logic [N_CLIENTS-1:0]         job_ready,
  output logic [N_CLIENTS-1:0]         req,
  output logic                         en,
  input  logic [N_CLIENTS-1:0]         gnt,
  output logic                         bus_valid,
  output logic [$clog2(N_CLIENTS)-1:0] bus_id,
  output logic [$clog2(BEATS)-1:0]     bus_beat,
  input  logic                         bus_ready,
  output logic [N_CLIENTS-1:0]         done,
  output logic                         err
);

  import req_issuer_pkg::*;

  localparam int unsigned ID_W   = $clog2(N_CLIENTS);
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [ID_W-1:0]      id_nxt;
  logic [BEAT_W-1:0]    beat_nxt;
  logic [N_CLIENTS-1:0] done_nxt;
  logic                 err_nxt;
  logic [N_CLIENTS-1:0] pop;
  logic [N_CLIENTS-1:0] req_nxt;
  logic                 gnt_onehot_c;
  logic [ID_W-1:0]      gnt_idx_c;

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_cnt
    req_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .push     (job_valid[i]),
      .pop      (pop[i]),
      .job_ready(job_ready[i]),
      .req      (req[i]),
      .req_nxt_c(req_nxt[i])
    );
  end

  // Grant decode: one-hot test and bit index.
  always_comb begin
    gnt_onehot_c = (gnt != '0) && ((gnt & (gnt - N_CLIENTS'(1))) == '0);
    gnt_idx_c    = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (gnt[i]) begin
        gnt_idx_c = ID_W'(i);
      end
    end
  end

  // Next state, burst tracking and completion/error flags.
  always_comb begin
    state_nxt = state;
    id_nxt    = bus_id;
    beat_nxt  = bus_beat;
    done_nxt  = '0;
    err_nxt   = err;
    pop       = '0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = ARB;
        end
      end
      ARB: begin
        if (gnt == '0) begin
          state_nxt = IDLE;
        end else if (gnt_onehot_c) begin
          id_nxt    = gnt_idx_c;
          beat_nxt  = '0;
          pop       = gnt;
          state_nxt = BURST;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      BURST: begin
        if (bus_ready) begin
          if (bus_beat == LAST_BEAT) begin
            done_nxt[bus_id] = 1'b1;
            state_nxt        = (|req_nxt) ? ARB : IDLE;
          end else begin
            beat_nxt = bus_beat + BEAT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // en and bus_valid are registered copies of the upcoming state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bus_id    <= '0;
      bus_beat  <= '0;
      done      <= '0;
      err       <= 1'b0;
      en        <= 1'b0;
      bus_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus_id    <= id_nxt;
      bus_beat  <= beat_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      en        <= (state_nxt == ARB);
      bus_valid <= (state_nxt == BURST);
    end
  end

endmodule

// File: tb/tb_req_issuer.sv
// Directed scoreboard bench for req_issuer with a highest-index-wins grant selector model.
module tb_req_issuer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] job_valid;
  logic [3:0] job_ready;
  logic [3:0] req;
  logic       en;
  logic [3:0] gnt;
  logic       bus_valid;
  logic [1:0] bus_id;
  logic [1:0] bus_beat;
  logic       bus_ready;
  logic [3:0] done;
  logic       err;
  logic       force_multi;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_beat[$];
  logic [3:0] exp_done[$];

  req_issuer dut (
    .clock    (clock),
    .reset    (reset),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .req      (req),
    .en       (en),
    .gnt      (gnt),
    .bus_valid(bus_valid),
    .bus_id   (bus_id),
    .bus_beat (bus_beat),
    .bus_ready(bus_ready),
    .done     (done),
    .err      (err)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] prio(input logic [3:0] r);
    logic [3:0] g;
    g = '0;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction

  assign gnt = !en ? 4'b0000 : (force_multi ? 4'b0011 : prio(req));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_burst(input logic [1:0] id);
    for (int b = 0; b < 4; b++) begin
      exp_beat.push_back({id, 2'(b)});
    end
    exp_done.push_back(4'b0001 << id);
  endtask

  task automatic wait_beat(input logic [1:0] id, input logic [1:0] beat, input string nm);
    int n = 0;
    while (!(bus_valid && bus_id == id && bus_beat == beat) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) timeout_fail(nm);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!(req == 4'b0 && !en && !bus_valid && done == 4'b0) && n < 600) begin
      tick();
      n++;
    end
    if (n >= 600) timeout_fail(nm);
  endtask

  // Monitor: every handshake and every done pulse must match the scoreboard head.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus_valid && bus_ready) begin
        if (exp_beat.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got id=%0d beat=%0d, wanted none", bus_id, bus_beat);
        end else begin
          chk("beat", {28'b0, bus_id, bus_beat}, {28'b0, exp_beat.pop_front()});
        end
      end
      if (done != 4'b0) begin
        if (exp_done.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: got %0h, wanted none", done);
        end else begin
          chk("done", {28'b0, done}, {28'b0, exp_done.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    job_valid   = 4'b0;
    bus_ready   = 1'b1;
    force_multi = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_job_ready", job_ready, 4'hF);
    chk("rst_req", req, 4'h0);
    chk("rst_en", en, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_done", done, 4'h0);
    chk("rst_err", err, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();

    // Single job for client 2 with cycle-exact latency.
    expect_burst(2'd2);
    job_valid = 4'b0100;
    tick();
    job_valid = 4'b0;
    chk("t1_req_c1", req, 4'b0100);
    chk("t1_en_c1", en, 0);
    tick();
    chk("t1_en_c2", en, 1);
    tick();
    chk("t1_valid_c3", bus_valid, 1);
    chk("t1_id_c3", bus_id, 2);
    chk("t1_beat_c3", bus_beat, 0);
    tick();
    tick();
    tick();
    chk("t1_beat_c6", bus_beat, 3);
    tick();
    chk("t1_done_c7", done, 4'b0100);
    chk("t1_valid_c7", bus_valid, 0);
    chk("t1_req_c7", req, 4'b0);
    wait_idle("t1_idle");

    // Clients 0 and 3 together: 3 first, then 0 with no idle gap.
    expect_burst(2'd3);
    expect_burst(2'd0);
    job_valid = 4'b1001;
    tick();
    job_valid = 4'b0;
    wait_beat(2'd3, 2'd3, "t2_last_beat");
    tick();
    chk("t2_en_after_last", en, 1);
    chk("t2_done3", done, 4'b1000);
    tick();
    chk("t2_valid_second", bus_valid, 1);
    chk("t2_id_second", bus_id, 0);
    wait_idle("t2_idle");

    // Saturation: eight pushes to client 1 while a burst for client 0 is stalled.
    bus_ready = 1'b0;
    expect_burst(2'd0);
    for (int k = 0; k < 7; k++) expect_burst(2'd1);
    job_valid = 4'b0001;
    tick();
    job_valid = 4'b0;
    wait_beat(2'd0, 2'd0, "t3_burst0");
    for (int i = 0; i < 8; i++) begin
      job_valid = 4'b0010;
      if (i == 6) chk("t3_ready_at6", job_ready[1], 1);
      if (i == 7) begin
        chk("t3_ready_full", job_ready[1], 0);
        chk("t3_req_full", req, 4'b0010);
      end
      tick();
    end
    job_valid = 4'b0;
    chk("t3_ready_after8", job_ready[1], 0);
    bus_ready = 1'b1;
    wait_idle("t3_idle");
    chk("t3_ready_drained", job_ready, 4'hF);

    // Backpressure at beat 1 for five cycles.
    expect_burst(2'd1);
    job_valid = 4'b0010;
    tick();
    job_valid = 4'b0;
    wait_beat(2'd1, 2'd1, "t4_beat1");
    bus_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_beat", bus_beat, 1);
      chk("t4_hold_id", bus_id, 1);
      chk("t4_hold_valid", bus_valid, 1);
      chk("t4_no_done", done, 4'b0);
    end
    bus_ready = 1'b1;
    wait_idle("t4_idle");

    // Multi-hot grant sets sticky err and leaves counters alone.
    chk("t5_err_pre", err, 0);
    force_multi = 1'b1;
    job_valid = 4'b0011;
    tick();
    job_valid = 4'b0;
    begin
      int n = 0;
      while (!en && n < 20) begin
        tick();
        n++;
      end
      if (n >= 20) timeout_fail("t5_wait_en");
    end
    tick();
    chk("t5_err_set", err, 1);
    chk("t5_en_off", en, 0);
    chk("t5_valid_off", bus_valid, 0);
    chk("t5_req_kept", req, 4'b0011);
    force_multi = 1'b0;
    expect_burst(2'd1);
    expect_burst(2'd0);
    wait_idle("t5_idle");
    chk("t5_err_sticky", err, 1);

    // Reset in the middle of a burst at beat 2.
    exp_beat.push_back({2'd3, 2'd0});
    exp_beat.push_back({2'd3, 2'd1});
    job_valid = 4'b1000;
    tick();
    job_valid = 4'b0;
    wait_beat(2'd3, 2'd2, "t6_beat2");
    reset = 1'b1;
    #1;
    chk("t6_valid_clr", bus_valid, 0);
    chk("t6_en_clr", en, 0);
    chk("t6_req_clr", req, 4'b0);
    chk("t6_ready_clr", job_ready, 4'hF);
    chk("t6_done_clr", done, 4'b0);
    chk("t6_err_clr", err, 0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t6_valid_after", bus_valid, 0);
    chk("t6_req_after", req, 4'b0);

    chk("beat_queue_empty", exp_beat.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
